// File: rtl/modadd_ctrl.sv
// Modular add/subtract sequencer: drives an external (N+1)-bit adder to form (a +/- b) mod m.
// Optional watchdog on each adder operation is compiled in with `define MODADD_TIMEOUT_EN.
module modadd_ctrl #(
  parameter int unsigned N              = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           subtract,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [N-1:0]   in_m,
  output logic [N-1:0]   result,
  output logic           done,
  output logic           busy,
  output logic           err,
  output logic           add_start,
  output logic           add_subtract,
  output logic [N:0]     add_a,
  output logic [N:0]     add_b,
  input  logic [N+1:0]   add_result,
  input  logic           add_done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    ISSUE2,
    WAIT2,
    FINISH
  } state_t;

  state_t         state;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   m_q;
  logic           sub_q;
  logic [N+1:0]   s_q;

`ifdef MODADD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0]  wd_cnt;
  logic           err_q;
  logic           wd_fire;

  // Counter is zero on the first wait cycle, so this fires after TIMEOUT_CYCLES idle cycles.
  assign wd_fire = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYCLES;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      m_q          <= '0;
      sub_q        <= 1'b0;
      s_q          <= '0;
      result       <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
`ifdef MODADD_TIMEOUT_EN
      wd_cnt       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      add_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            sub_q <= subtract;
            busy  <= 1'b1;
`ifdef MODADD_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            state <= ISSUE1;
          end
        end

        ISSUE1: begin
          add_a        <= {1'b0, a_q};
          add_b        <= {1'b0, b_q};
          add_subtract <= sub_q;
          add_start    <= 1'b1;
`ifdef MODADD_TIMEOUT_EN
          wd_cnt       <= '0;
`endif
          state        <= WAIT1;
        end

        WAIT1: begin
          if (add_done) begin
            s_q <= add_result;
            // A non-negative difference is already reduced; everything else needs a correction op.
            if (sub_q && !add_result[N+1]) begin
              result <= add_result[N-1:0];
              state  <= FINISH;
            end else begin
              state  <= ISSUE2;
            end
          end
`ifdef MODADD_TIMEOUT_EN
          else if (wd_fire) begin
            err_q  <= 1'b1;
            result <= '0;
            state  <= FINISH;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        ISSUE2: begin
          // Add mode tries s - m; subtract mode adds m back to the wrapped negative difference.
          add_a        <= s_q[N:0];
          add_b        <= {1'b0, m_q};
          add_subtract <= !sub_q;
          add_start    <= 1'b1;
`ifdef MODADD_TIMEOUT_EN
          wd_cnt       <= '0;
`endif
          state        <= WAIT2;
        end

        WAIT2: begin
          if (add_done) begin
            if (sub_q || !add_result[N+1]) begin
              result <= add_result[N-1:0];
            end else begin
              result <= s_q[N-1:0];
            end
            state <= FINISH;
          end
`ifdef MODADD_TIMEOUT_EN
          else if (wd_fire) begin
            err_q  <= 1'b1;
            result <= '0;
            state  <= FINISH;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modadd_ctrl.sv
// Randomised and directed bench for modadd_ctrl against a 3-cycle adder model and a
// plain-arithmetic (a +/- b) mod m reference.
module tb_modadd_ctrl;

  localparam int unsigned N   = 512;
  localparam int unsigned LAT = 3;

  logic           clk = 1'b0;
  logic           resetn;
  logic           start;
  logic           subtract;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic [N-1:0]   in_m;
  logic [N-1:0]   result;
  logic           done;
  logic           busy;
  logic           err;
  logic           add_start;
  logic           add_subtract;
  logic [N:0]     add_a;
  logic [N:0]     add_b;
  logic [N+1:0]   add_result;
  logic           add_done;

  int n_checks = 0;
  int n_errors = 0;

  modadd_ctrl #(
    .N              (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .subtract     (subtract),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .result       (result),
    .done         (done),
    .busy         (busy),
    .err          (err),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  always #5 clk = ~clk;

  // Behavioural adder: fixed latency, optionally never answers.
  logic          hang = 1'b0;
  logic [N+1:0]  lat_res;
  int            lat_cnt;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      add_done   <= 1'b0;
      add_result <= '0;
      lat_res    <= '0;
      lat_cnt    <= 0;
    end else begin
      add_done <= 1'b0;
      if (add_start) begin
        lat_cnt <= LAT;
        lat_res <= add_subtract ? ({1'b0, add_a} - {1'b0, add_b})
                                : ({1'b0, add_a} + {1'b0, add_b});
      end else if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1 && !hang) begin
          add_done   <= 1'b1;
          add_result <= lat_res;
        end
      end
    end
  end

  // Transaction monitor: logs each adder operation and watches operand stability.
  logic [N:0]  op_a_q[$];
  logic [N:0]  op_b_q[$];
  logic        op_sub_q[$];
  logic [N:0]  pa;
  logic [N:0]  pb;
  logic        psub;
  logic        pending = 1'b0;
  int          n_unstable = 0;
  int          n_done = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      pending <= 1'b0;
    end else begin
      if (add_start) begin
        op_a_q.push_back(add_a);
        op_b_q.push_back(add_b);
        op_sub_q.push_back(add_subtract);
        pa      <= add_a;
        pb      <= add_b;
        psub    <= add_subtract;
        pending <= 1'b1;
      end else if (pending) begin
        if (add_a !== pa || add_b !== pb || add_subtract !== psub)
          n_unstable <= n_unstable + 1;
        if (add_done)
          pending <= 1'b0;
      end
      if (done)
        n_done <= n_done + 1;
    end
  end

  task automatic check(input string tag, input logic [N+1:0] got, input logic [N+1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_mod(input logic sub, input logic [N-1:0] a,
                                           input logic [N-1:0] b, input logic [N-1:0] m);
    logic [N+1:0] wa;
    logic [N+1:0] wb;
    logic [N+1:0] wm;
    wa = {2'b00, a};
    wb = {2'b00, b};
    wm = {2'b00, m};
    if (sub) return N'((wa + wm - wb) % wm);
    else     return N'((wa + wb) % wm);
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] v;
    for (int unsigned i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_op(input string tag, input logic sub, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] m, input logic poke,
                        output int first_op);
    int n0;
    int u0;
    int exp_ops;
    logic [N-1:0] exp_res;
    first_op = op_a_q.size();
    n0       = n_done;
    u0       = n_unstable;
    exp_res  = ref_mod(sub, a, b, m);
    exp_ops  = (sub && a >= b) ? 1 : 2;
    @(negedge clk);
    start    = 1'b1;
    subtract = sub;
    in_a     = a;
    in_b     = b;
    in_m     = m;
    @(negedge clk);
    start    = 1'b0;
    subtract = ~sub;
    in_a     = rand_wide();
    in_b     = rand_wide();
    check({tag, "_busy"}, busy, 1);
    for (int unsigned i = 0; i < 300; i++) begin
      if (done) break;
      start = poke && (i == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, err, 0);
    repeat (3) @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_result_hold"}, result, exp_res);
    check({tag, "_ndone"}, n_done - n0, 1);
    check({tag, "_nops"}, op_a_q.size() - first_op, exp_ops);
    check({tag, "_stable"}, n_unstable - u0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int f;
    int n0;
    logic [N-1:0] m;
    logic [N-1:0] a;
    logic [N-1:0] b;

    resetn   = 1'b1;
    start    = 1'b0;
    subtract = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_m     = '0;
    #2 resetn = 1'b0;
    #1;
    check("rst_result", result, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_ctrl", {done, busy, err, add_start, add_subtract}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run_op("add_7_9", 1'b0, 7, 9, 13, 1'b0, f);
    check("add_7_9_op2_sub", op_sub_q[f+1], 1);
    check("add_7_9_op2_a", op_a_q[f+1], 16);
    check("add_7_9_op2_b", op_b_q[f+1], 13);
    run_op("add_3_4", 1'b0, 3, 4, 13, 1'b0, f);
    run_op("add_5_8", 1'b0, 5, 8, 13, 1'b0, f);
    run_op("sub_9_3", 1'b1, 9, 3, 13, 1'b0, f);
    check("sub_9_3_op1_sub", op_sub_q[f], 1);
    run_op("sub_3_9", 1'b1, 3, 9, 13, 1'b1, f);
    check("sub_3_9_op2_sub", op_sub_q[f+1], 0);
    run_op("sub_eq", 1'b1, 4, 4, 13, 1'b0, f);

    m = '1;
    run_op("large_add", 1'b0, m - 1'b1, m - 1'b1, m, 1'b0, f);
    check("large_add_val", result, {{(N-2){1'b1}}, 2'b01});
    run_op("large_sub", 1'b1, 0, m - 1'b1, m, 1'b0, f);

    for (int unsigned k = 0; k < 24; k++) begin
      if (k % 2 == 0) m = rand_wide();
      else            m = N'($urandom_range(1, 1000));
      if (m == '0) m = 1;
      a = rand_wide() % m;
      b = rand_wide() % m;
      if (k % 3 == 0) b = a;
      run_op($sformatf("rand%0d", k), k[0] ^ k[2], a, b, m, (k % 4) == 1, f);
    end

    // Reset while the first adder operation is outstanding.
    n0 = n_done;
    f  = op_a_q.size();
    @(negedge clk);
    start    = 1'b1;
    subtract = 1'b0;
    in_a     = 11;
    in_b     = 12;
    in_m     = 13;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (op_a_q.size() > f) break;
      @(negedge clk);
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_result", result, 0);
    check("midrst_add_a", add_a, 0);
    check("midrst_add_b", add_b, 0);
    check("midrst_ctrl", {done, busy, err, add_start, add_subtract}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", n_done - n0, 0);
    check("midrst_busy", busy, 0);
    run_op("post_rst_1_1", 1'b0, 1, 1, 13, 1'b0, f);

`ifdef MODADD_TIMEOUT_EN
    hang = 1'b1;
    @(negedge clk);
    start    = 1'b1;
    subtract = 1'b0;
    in_a     = 1;
    in_b     = 2;
    in_m     = 13;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("wd_done", done, 1);
    check("wd_err", err, 1);
    check("wd_result", result, 0);
    repeat (3) @(negedge clk);
    check("wd_err_hold", err, 1);
    hang = 1'b0;
    repeat (5) @(negedge clk);
    run_op("wd_recover", 1'b0, 6, 10, 13, 1'b0, f);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/modadd_ctrl.md
Name: modadd_ctrl

Overview:
- Sequencer that computes modular add/subtract, (a ± b) mod m, on 512-bit operands.
- Acts as the initiator of the multi-precision adder's start/subtract/done handshake; the adder is instantiated outside and wired to the add_* ports.
- Issues one or two adder operations per request, then selects or corrects the final value.
- Sits between the top-level controller (e.g. Montgomery/exponentiation FSM) and the adder.

Parameters:
- N, 512, operand/modulus width. Adder ports are N+1 in and N+2 out.
- TIMEOUT_CYCLES, 1024, watchdog limit per adder operation. Used only with MODADD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- subtract  in  1  0 = (a+b) mod m, 1 = (a−b) mod m; sampled with start.
- in_a  in  N  operand a; precondition a < m.
- in_b  in  N  operand b; precondition b < m.
- in_m  in  N  modulus; precondition m > 0.
- result  out  N  modular result; valid from the done pulse until the next start.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after start is accepted until done.
- err  out  1  watchdog fired (MODADD_TIMEOUT_EN only; tied 0 otherwise).
- add_start  out  1  one-cycle pulse to the adder.
- add_subtract  out  1  adder mode; held stable from add_start until add_done.
- add_a  out  N+1  adder operand a; held stable from add_start until add_done.
- add_b  out  N+1  adder operand b; held stable from add_start until add_done.
- add_result  in  N+2  adder result; two's complement, bit N+1 = sign for subtract.
- add_done  in  1  adder completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE; result, done, busy, err, add_start, add_subtract, add_a, add_b all 0.
- A reset mid-operation abandons the operation. No done is produced.
- In IDLE, start=1 latches a, b, m and subtract into internal registers. Inputs may change afterwards.
- States and transitions:
  - IDLE -> ISSUE1 on start.
  - ISSUE1: add_a={0,a}, add_b={0,b}, add_subtract=subtract, add_start=1 for exactly one cycle. -> WAIT1.
  - WAIT1: wait for add_done. Capture s=add_result into a 514-bit register.
    - Add mode -> ISSUE2.
    - Subtract mode with s[N+1]=0 -> FINISH with result=s[N-1:0]. Single adder op.
    - Subtract mode with s[N+1]=1 -> ISSUE2.
  - ISSUE2, add mode: add_a=s[N:0], add_b={0,m}, add_subtract=1. One-cycle add_start. -> WAIT2.
  - ISSUE2, subtract mode: add_a=s[N:0], add_b={0,m}, add_subtract=0. One-cycle add_start. -> WAIT2.
  - WAIT2: on add_done, t=add_result.
    - Add mode: result = t[N+1]=0 ? t[N-1:0] : s[N-1:0].
    - Subtract mode: result = t[N-1:0]. The carry out of 2^(N+1) is discarded.
    - -> FINISH.
  - FINISH: done=1 for one cycle, busy=0. -> IDLE.
- Latency: done asserts 2 cycles after the final add_done edge. Total = 1 (accept) + per op (1 issue + adder latency + 1 capture) + 1 finish.
- start while busy is ignored (not queued).
- add_done outside WAIT1/WAIT2 is ignored.
- add_done coincident with add_start is not possible; the adder needs at least 1 cycle.
- Out-of-range operands (a or b ≥ m): result undefined but done still pulses. No hang.
- result holds its value after done until the next accepted start.

Optional Feature:
- MODADD_TIMEOUT_EN defined:
  - A per-operation counter resets at each add_start and increments in WAIT1/WAIT2.
  - Reaching TIMEOUT_CYCLES with no add_done -> err=1, result=0, FINISH (done pulses).
  - err stays high until the next accepted start.
- MODADD_TIMEOUT_EN undefined: no counter, err tied 0, WAIT states wait indefinitely.

Test Plan:
- Use N=512 and a behavioural adder model with a 3-cycle latency; m=13 unless stated.
- add, a=7, b=9 -> two adder ops; second op add_subtract=1, add_a=16, add_b=13; result=3, done once, busy low after.
- add, a=3, b=4 -> result=7 (second op negative, s selected). add, a=5, b=8 -> result=0 (equality boundary).
- sub, a=9, b=3 -> exactly one add_start; result=6. sub, a=3, b=9 -> two ops, second add_subtract=0; result=7.
- Large: m=2^512−1, a=m−1, b=m−1 -> result=2^512−3. Check add_a/add_b are stable between add_start and add_done.
- Assert resetn low in WAIT1, then release -> all outputs 0, no done pulse; a new add 1+1 (m=13) -> result=2.
- MODADD_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a model that never raises add_done -> err=1 and done pulse; a following good request clears err.
